// File: rtl/duck_hit_detector.sv
// Turns a raw left-button press into exactly one registered hit-or-miss pulse per press.
// It synchronises the button, snapshots the cursor and duck, runs a bounding-box test, then locks out.
//
// state   | meaning
// S_IDLE  | waiting for a synchronised press while game_on is high
// S_EVAL  | one cycle: bounding-box test on snapshotted coordinates, pulse registered
// S_COOL  | lockout: counter runs down, exit needs counter 0 and button released
module duck_hit_detector #(
    parameter int X_W      = 12,
    parameter int Y_W      = 12,
    parameter int DUCK_W   = 64,
    parameter int DUCK_H   = 64,
    parameter int COOLDOWN = 1024
) (
    input  logic           pclk,
    input  logic           rst,
    input  logic           mouse_left,
    input  logic [X_W-1:0] mouse_xpos,
    input  logic [Y_W-1:0] mouse_ypos,
    input  logic [X_W-1:0] duck_xpos,
    input  logic [Y_W-1:0] duck_ypos,
    input  logic           duck_active,
    input  logic           game_on,
    output logic           clicked_duck,
    output logic           missed_shot,
    output logic           busy
);

    localparam int CNT_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_COOL = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             dly_q, dly_d;
    logic [X_W-1:0]   snap_mx_q, snap_mx_d;
    logic [Y_W-1:0]   snap_my_q, snap_my_d;
    logic [X_W-1:0]   snap_dx_q, snap_dx_d;
    logic [Y_W-1:0]   snap_dy_q, snap_dy_d;
    logic             snap_active_q, snap_active_d;
    logic             clicked_q, clicked_d;
    logic             missed_q, missed_d;

    logic             press;
    logic             hit;
    logic [X_W:0]     mx_ext, dx_ext, dx_end;
    logic [Y_W:0]     my_ext, dy_ext, dy_end;

    // One extra bit keeps the right/bottom bound from wrapping for a duck at the screen edge.
    always_comb begin
        mx_ext = {1'b0, snap_mx_q};
        dx_ext = {1'b0, snap_dx_q};
        dx_end = dx_ext + (X_W+1)'(DUCK_W);
        my_ext = {1'b0, snap_my_q};
        dy_ext = {1'b0, snap_dy_q};
        dy_end = dy_ext + (Y_W+1)'(DUCK_H);
        hit    = snap_active_q
               & (dx_ext <= mx_ext) & (mx_ext < dx_end)
               & (dy_ext <= my_ext) & (my_ext < dy_end);
    end

    assign press = sync2_q & ~dly_q;

    always_comb begin
        sync1_d       = mouse_left;
        sync2_d       = sync1_q;
        dly_d         = sync2_q;
        state_d       = state_q;
        cnt_d         = cnt_q;
        snap_mx_d     = snap_mx_q;
        snap_my_d     = snap_my_q;
        snap_dx_d     = snap_dx_q;
        snap_dy_d     = snap_dy_q;
        snap_active_d = snap_active_q;
        clicked_d     = 1'b0;
        missed_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (press && game_on) begin
                    snap_mx_d     = mouse_xpos;
                    snap_my_d     = mouse_ypos;
                    snap_dx_d     = duck_xpos;
                    snap_dy_d     = duck_ypos;
                    snap_active_d = duck_active;
                    state_d       = S_EVAL;
                end
            end
            S_EVAL: begin
                clicked_d = hit;
                missed_d  = ~hit;
                cnt_d     = CNT_LOAD;
                state_d   = S_COOL;
            end
            S_COOL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!sync2_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Synchroniser resets high so a button held through reset must be released before it counts.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            dly_q         <= 1'b1;
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            snap_mx_q     <= '0;
            snap_my_q     <= '0;
            snap_dx_q     <= '0;
            snap_dy_q     <= '0;
            snap_active_q <= 1'b0;
            clicked_q     <= 1'b0;
            missed_q      <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            dly_q         <= dly_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            snap_mx_q     <= snap_mx_d;
            snap_my_q     <= snap_my_d;
            snap_dx_q     <= snap_dx_d;
            snap_dy_q     <= snap_dy_d;
            snap_active_q <= snap_active_d;
            clicked_q     <= clicked_d;
            missed_q      <= missed_d;
        end
    end

    assign clicked_duck = clicked_q;
    assign missed_shot  = missed_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_duck_hit_detector.sv
// Directed bench for duck_hit_detector: table of hit-test vectors plus hand-written lockout/reset sequences.
module tb_duck_hit_detector;

    logic        pclk = 1'b0;
    logic        rst;
    logic        mouse_left;
    logic [11:0] mouse_xpos, mouse_ypos, duck_xpos, duck_ypos;
    logic        duck_active, game_on;
    logic        clicked_duck, missed_shot, busy;

    int errors = 0;
    int checks = 0;
    int hit_cnt = 0;
    int miss_cnt = 0;
    bit busy_seen = 0;

    duck_hit_detector dut (
        .pclk(pclk), .rst(rst), .mouse_left(mouse_left),
        .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
        .duck_xpos(duck_xpos), .duck_ypos(duck_ypos),
        .duck_active(duck_active), .game_on(game_on),
        .clicked_duck(clicked_duck), .missed_shot(missed_shot), .busy(busy)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        if (clicked_duck) hit_cnt++;
        if (missed_shot) miss_cnt++;
        if (busy) busy_seen = 1;
    end

    typedef struct {
        string       name;
        logic [11:0] dx, dy, mx, my;
        logic        active;
        logic        exp_hit;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge pclk);
        #1;
    endtask

    // Press at the next edge N and check the N+2 / N+3 / N+4 timing; optionally disturb inputs after the snapshot.
    task automatic do_shot(input string name, input logic exp_hit, input bit perturb);
        @(negedge pclk) mouse_left = 1'b1;
        @(posedge pclk);
        @(posedge pclk); #1;
        check({name, "_busy_n1"}, busy, 0);
        @(posedge pclk); #1;
        check({name, "_busy_n2"}, busy, 1);
        check({name, "_pulse_n2"}, {clicked_duck, missed_shot}, 0);
        if (perturb) begin
            mouse_xpos = 12'd0; mouse_ypos = 12'd0;
            duck_active = 1'b0; game_on = 1'b0;
        end
        @(posedge pclk); #1;
        check({name, "_clicked_n3"}, clicked_duck, exp_hit);
        check({name, "_missed_n3"}, missed_shot, !exp_hit);
        @(posedge pclk); #1;
        check({name, "_pulse_n4"}, {clicked_duck, missed_shot}, 0);
    endtask

    task automatic release_and_idle(input string name);
        int n;
        mouse_left = 1'b0;
        n = 0;
        while (busy && n < 1200) begin
            @(posedge pclk); #1;
            n++;
        end
        check({name, "_idle_return"}, busy, 0);
        wait_cycles(3);
    endtask

    task automatic set_pos(input logic [11:0] dx, dy, mx, my, input logic act);
        duck_xpos = dx; duck_ypos = dy; mouse_xpos = mx; mouse_ypos = my;
        duck_active = act; game_on = 1'b1;
    endtask

    initial begin
        int h0, m0;
        vecs[0] = '{"inside",      12'd100,  12'd100, 12'd130,  12'd140, 1'b1, 1'b1};
        vecs[1] = '{"top_left",    12'd100,  12'd100, 12'd100,  12'd100, 1'b1, 1'b1};
        vecs[2] = '{"right_excl",  12'd100,  12'd100, 12'd164,  12'd130, 1'b1, 1'b0};
        vecs[3] = '{"bot_right",   12'd100,  12'd100, 12'd163,  12'd163, 1'b1, 1'b1};
        vecs[4] = '{"left_out",    12'd100,  12'd100, 12'd99,   12'd130, 1'b1, 1'b0};
        vecs[5] = '{"bottom_excl", 12'd100,  12'd100, 12'd130,  12'd164, 1'b1, 1'b0};
        vecs[6] = '{"top_out",     12'd100,  12'd100, 12'd130,  12'd99,  1'b1, 1'b0};
        vecs[7] = '{"edge_nowrap", 12'd4060, 12'd10,  12'd4090, 12'd20,  1'b1, 1'b1};
        vecs[8] = '{"edge_max",    12'd4060, 12'd10,  12'd4095, 12'd73,  1'b1, 1'b1};
        vecs[9] = '{"inactive",    12'd100,  12'd100, 12'd130,  12'd140, 1'b0, 1'b0};

        rst = 1'b0; mouse_left = 1'b0;
        set_pos(12'd100, 12'd100, 12'd130, 12'd140, 1'b1);
        wait_cycles(3);
        check("reset_clicked", clicked_duck, 0);
        check("reset_missed", missed_shot, 0);
        check("reset_busy", busy, 0);
        @(negedge pclk) rst = 1'b1;
        wait_cycles(5);

        foreach (vecs[i]) begin
            set_pos(vecs[i].dx, vecs[i].dy, vecs[i].mx, vecs[i].my, vecs[i].active);
            do_shot(vecs[i].name, vecs[i].exp_hit, 1'b0);
            release_and_idle(vecs[i].name);
        end

        // Inputs change right after the snapshot, game_on drops: decision still a hit.
        set_pos(12'd100, 12'd100, 12'd130, 12'd140, 1'b1);
        do_shot("snapshot_hold", 1'b1, 1'b1);
        release_and_idle("snapshot_hold");
        set_pos(12'd100, 12'd100, 12'd130, 12'd140, 1'b1);

        // Held button: one decision, lockout persists until release.
        h0 = hit_cnt; m0 = miss_cnt;
        do_shot("held", 1'b1, 1'b0);
        wait_cycles(5000);
        check("held_single_pulse", hit_cnt - h0, 1);
        check("held_no_miss", miss_cnt - m0, 0);
        check("held_still_busy", busy, 1);
        release_and_idle("held");

        // Re-press during cooldown is dropped; a press after release and cooldown works.
        h0 = hit_cnt; m0 = miss_cnt;
        do_shot("first", 1'b1, 1'b0);
        mouse_left = 1'b0;
        wait_cycles(8);
        mouse_left = 1'b1;
        wait_cycles(20);
        release_and_idle("cool_press");
        check("cool_press_ignored", (hit_cnt - h0) + (miss_cnt - m0), 1);
        do_shot("second", 1'b1, 1'b0);
        release_and_idle("second");

        // game_on low: press discarded entirely.
        h0 = hit_cnt; m0 = miss_cnt;
        game_on = 1'b0; busy_seen = 0;
        @(negedge pclk) mouse_left = 1'b1;
        wait_cycles(10);
        mouse_left = 1'b0;
        wait_cycles(5);
        check("gameoff_busy", busy_seen, 0);
        check("gameoff_pulse", (hit_cnt - h0) + (miss_cnt - m0), 0);
        game_on = 1'b1;

        // Async reset while in EVAL, button held across reset release.
        h0 = hit_cnt; m0 = miss_cnt;
        @(negedge pclk) mouse_left = 1'b1;
        wait_cycles(3);
        check("pre_reset_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_pulse", {clicked_duck, missed_shot}, 0);
        wait_cycles(3);
        @(negedge pclk) rst = 1'b1;
        wait_cycles(20);
        check("held_through_reset_pulse", (hit_cnt - h0) + (miss_cnt - m0), 0);
        check("held_through_reset_busy", busy, 0);
        mouse_left = 1'b0;
        wait_cycles(5);
        do_shot("after_reset", 1'b1, 1'b0);
        release_and_idle("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
